// File: rtl/decode_arbiter.sv
// decode_arbiter: round-robin arbiter that shares one pipelined decoder among NUM_REQ requesters
// and routes each decoded word back to its originator. Grant counters exist only with DECODE_ARB_STATS_EN.
module decode_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ENC_WIDTH   = 21,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned DEC_LATENCY = 1,
  localparam int unsigned IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*ENC_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [ENC_WIDTH-1:0]           dec_encoded,
  input  logic [DATA_WIDTH-1:0]          dec_decoded,
  input  logic                           dec_valid,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_WIDTH-1:0]          rsp_data,
  output logic                           idle,
  output logic                           tag_err
`ifdef DECODE_ARB_STATS_EN
  ,
  input  logic [IDX_W-1:0]               stat_sel,
  output logic [15:0]                    stat_count
`endif
);

  localparam int unsigned        FLUSH_W    = $clog2(DEC_LATENCY + 2);
  localparam logic [IDX_W-1:0]   PTR_RST    = IDX_W'(NUM_REQ - 1);
  localparam logic [FLUSH_W-1:0] FLUSH_LOAD = FLUSH_W'(DEC_LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [IDX_W-1:0]     ptr;
  logic [IDX_W-1:0]     grant_idx;
  logic [IDX_W-1:0]     cand;
  logic                 grant_found;
  logic                 xfer;
  logic                 pipe_empty;
  logic [DEC_LATENCY:0] tag_v;
  logic [IDX_W-1:0]     tag_idx [DEC_LATENCY+1];
  logic [FLUSH_W-1:0]   flush_cnt;
  logic                 rsp_hit;
  logic                 stray;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable) state_next = RUN;
      RUN:     if (!enable) state_next = DRAIN;
      DRAIN: begin
        if (enable) begin
          state_next = RUN;
        end else if (pipe_empty) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idle <= 1'b1;
    end else begin
      idle <= (state_next == IDLE);
    end
  end

  // Round-robin search starting one past the last granted requester
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = ptr;
    cand        = ptr;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      cand = IDX_W'((int'(ptr) + k) % int'(NUM_REQ));
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign xfer      = grant_found && enable && (state == RUN) && !rst;
  assign req_ready = xfer ? (NUM_REQ'(1) << grant_idx) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= PTR_RST;
      dec_encoded <= '0;
    end else if (xfer) begin
      ptr         <= grant_idx;
      dec_encoded <= req_data[int'(grant_idx) * int'(ENC_WIDTH) +: ENC_WIDTH];
    end
  end

  // Stage 0 pairs with dec_encoded; stage DEC_LATENCY lines up with the decoder output
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v <= '0;
      for (int k = 0; k <= int'(DEC_LATENCY); k++) begin
        tag_idx[k] <= '0;
      end
    end else begin
      tag_v      <= {tag_v[DEC_LATENCY-1:0], xfer};
      tag_idx[0] <= grant_idx;
      for (int k = 1; k <= int'(DEC_LATENCY); k++) begin
        tag_idx[k] <= tag_idx[k-1];
      end
    end
  end

  assign pipe_empty = ~|tag_v;
  assign rsp_hit    = dec_valid && tag_v[DEC_LATENCY] && !rst;
  assign rsp_valid  = rsp_hit ? (NUM_REQ'(1) << tag_idx[DEC_LATENCY]) : '0;
  assign rsp_data   = rsp_hit ? dec_decoded : '0;
  assign stray      = dec_valid && !tag_v[DEC_LATENCY] && (flush_cnt == '0);

  // Words already inside the decoder at reset still emerge; ignore them for one latency window
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt <= FLUSH_LOAD;
      tag_err   <= 1'b0;
    end else begin
      if (flush_cnt != '0) begin
        flush_cnt <= flush_cnt - FLUSH_W'(1);
      end
      if (stray) begin
        tag_err <= 1'b1;
      end
    end
  end

`ifdef DECODE_ARB_STATS_EN
  logic [15:0] grant_cnt [NUM_REQ];

  // Saturating per-requester grant counters
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        grant_cnt[i] <= '0;
      end
      stat_count <= '0;
    end else begin
      if (xfer && (grant_cnt[grant_idx] != 16'hFFFF)) begin
        grant_cnt[grant_idx] <= grant_cnt[grant_idx] + 16'd1;
      end
      stat_count <= (int'(stat_sel) < int'(NUM_REQ)) ? grant_cnt[stat_sel] : '0;
    end
  end
`endif

endmodule
